// File: rtl/framebuffer_scanout.sv
// Framebuffer scanout: raster timing generator, word prefetch from a
// sync-read RAM port into a small FIFO, and pixel unpacking to the DAC.
// All video outputs are registered and lag the raster counters by one clock.
module framebuffer_scanout #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int PIX_BITS   = 8,
  parameter int H_ACTIVE   = 640,
  parameter int H_FP       = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BP       = 48,
  parameter int V_ACTIVE   = 480,
  parameter int V_FP       = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BP       = 33,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_sink_reset_n,
  input  logic                  enable,
  input  logic [ADDR_WIDTH-1:0] base_address,
  output logic [ADDR_WIDTH-1:0] rd_address,
  output logic                  rd_en,
  input  logic [WIDTH-1:0]      rd_data,
  output logic                  de,
  output logic                  hsync,
  output logic                  vsync,
  output logic [PIX_BITS-1:0]   pixel,
  output logic                  vblank_irq,
  output logic                  underflow
);

  localparam int PIX_PER_WORD = WIDTH / PIX_BITS;
  localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int FRAME_WORDS  = (H_ACTIVE * V_ACTIVE) / PIX_PER_WORD;
  localparam int HC_W         = $clog2(H_TOTAL);
  localparam int VC_W         = $clog2(V_TOTAL);
  localparam int IDX_W        = $clog2(FRAME_WORDS + 1);
  localparam int PTR_W        = $clog2(FIFO_DEPTH);
  localparam int CNT_W        = PTR_W + 1;
  localparam int OCC_W        = PTR_W + 2;
  localparam int K_W          = (PIX_PER_WORD > 1) ? $clog2(PIX_PER_WORD) : 1;

  localparam logic [HC_W-1:0]  H_ACT_C  = HC_W'(H_ACTIVE);
  localparam logic [HC_W-1:0]  H_SS_C   = HC_W'(H_ACTIVE + H_FP);
  localparam logic [HC_W-1:0]  H_SE_C   = HC_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HC_W-1:0]  H_LAST_C = HC_W'(H_TOTAL - 1);
  localparam logic [VC_W-1:0]  V_ACT_C  = VC_W'(V_ACTIVE);
  localparam logic [VC_W-1:0]  V_SS_C   = VC_W'(V_ACTIVE + V_FP);
  localparam logic [VC_W-1:0]  V_SE_C   = VC_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VC_W-1:0]  V_LAST_C = VC_W'(V_TOTAL - 1);
  localparam logic [IDX_W-1:0] WORDS_C  = IDX_W'(FRAME_WORDS);
  localparam logic [OCC_W-1:0] DEPTH_C  = OCC_W'(FIFO_DEPTH);
  localparam logic [K_W-1:0]   K_LAST_C = K_W'(PIX_PER_WORD - 1);

  if ((H_ACTIVE * V_ACTIVE) % PIX_PER_WORD != 0) begin : g_chk_words
    $error("active pixel count must be a multiple of pixels per word");
  end
  if ((FIFO_DEPTH < 2) || ((1 << PTR_W) != FIFO_DEPTH)) begin : g_chk_depth
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end

  logic [HC_W-1:0]       r_h_cnt;
  logic [VC_W-1:0]       r_v_cnt;
  logic                  r_en_lat;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [IDX_W-1:0]      r_idx;
  logic                  r_rd_en;
  logic                  r_rd_vld;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic [WIDTH-1:0]      r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [CNT_W-1:0]      r_count;
  logic [K_W-1:0]        r_k;
  logic                  r_de;
  logic                  r_hsync;
  logic                  r_vsync;
  logic [PIX_BITS-1:0]   r_pixel;
  logic                  r_irq;
  logic                  r_underflow;

  logic                  w_h_wrap;
  logic                  w_frame_start;
  logic                  w_active;
  logic [OCC_W-1:0]      w_occ;
  logic                  w_fetch;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_consume;
  logic                  w_starve;
  logic [WIDTH-1:0]      w_head;
  logic [PIX_BITS-1:0]   w_pix;

  assign w_h_wrap      = (r_h_cnt == H_LAST_C);
  assign w_frame_start = (r_h_cnt == '0) && (r_v_cnt == V_LAST_C);
  assign w_active      = (r_h_cnt < H_ACT_C) && (r_v_cnt < V_ACT_C);

  // Occupancy counts words already issued but not yet pushed, so the FIFO cannot overflow.
  assign w_occ     = OCC_W'(r_count) + OCC_W'(r_rd_en) + OCC_W'(r_rd_vld);
  assign w_fetch   = r_en_lat && (r_idx < WORDS_C) && (w_occ < DEPTH_C) && !w_frame_start;
  // Data returning across a frame start belongs to the old frame and is dropped.
  assign w_push    = r_rd_vld && !w_frame_start;
  assign w_consume = w_active && r_en_lat && (r_count != '0);
  assign w_starve  = w_active && r_en_lat && (r_count == '0);
  assign w_pop     = w_consume && (r_k == K_LAST_C);

  // Select the current pixel slice from the FIFO head word, low bits first.
  always_comb begin
    w_head = r_mem[r_rd_ptr];
    w_pix  = '0;
    for (int i = 0; i < PIX_PER_WORD; i++) begin
      if (r_k == K_W'(i)) w_pix = w_head[i*PIX_BITS +: PIX_BITS];
    end
  end

  // Raster counters: h free-runs, v advances on h wrap.
  always_ff @(posedge clk or negedge reset_sink_reset_n) begin
    if (!reset_sink_reset_n) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else begin
      r_h_cnt <= w_h_wrap ? '0 : r_h_cnt + HC_W'(1);
      if (w_h_wrap) r_v_cnt <= (r_v_cnt == V_LAST_C) ? '0 : r_v_cnt + VC_W'(1);
    end
  end

  // Frame configuration latch and read issue; restarted at every frame start.
  always_ff @(posedge clk or negedge reset_sink_reset_n) begin
    if (!reset_sink_reset_n) begin
      r_en_lat  <= 1'b0;
      r_base    <= '0;
      r_idx     <= '0;
      r_rd_en   <= 1'b0;
      r_rd_vld  <= 1'b0;
      r_rd_addr <= '0;
    end else begin
      r_rd_en  <= w_fetch;
      r_rd_vld <= r_rd_en && !w_frame_start;
      if (w_frame_start) begin
        r_en_lat <= enable;
        r_base   <= base_address;
        r_idx    <= '0;
      end else if (w_fetch) begin
        r_idx     <= r_idx + IDX_W'(1);
        r_rd_addr <= r_base + ADDR_WIDTH'(r_idx);
      end
    end
  end

  // FIFO storage; contents need no reset since the count gates every read.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= rd_data;
  end

  // FIFO pointers, count and pixel slice index.
  always_ff @(posedge clk or negedge reset_sink_reset_n) begin
    if (!reset_sink_reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_k      <= '0;
    end else if (w_frame_start) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_k      <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (w_consume) r_k <= (r_k == K_LAST_C) ? '0 : r_k + K_W'(1);
    end
  end

  // Registered video outputs, one clock behind the counters.
  always_ff @(posedge clk or negedge reset_sink_reset_n) begin
    if (!reset_sink_reset_n) begin
      r_de        <= 1'b0;
      r_hsync     <= 1'b1;
      r_vsync     <= 1'b1;
      r_pixel     <= '0;
      r_irq       <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_de    <= w_active;
      r_hsync <= !((r_h_cnt >= H_SS_C) && (r_h_cnt < H_SE_C));
      r_vsync <= !((r_v_cnt >= V_SS_C) && (r_v_cnt < V_SE_C));
      r_pixel <= w_consume ? w_pix : '0;
      r_irq   <= (r_h_cnt == '0) && (r_v_cnt == V_ACT_C);
      if (w_frame_start)  r_underflow <= 1'b0;
      else if (w_starve)  r_underflow <= 1'b1;
    end
  end

  assign rd_en      = r_rd_en;
  assign rd_address = r_rd_addr;
  assign de         = r_de;
  assign hsync      = r_hsync;
  assign vsync      = r_vsync;
  assign pixel      = r_pixel;
  assign vblank_irq = r_irq;
  assign underflow  = r_underflow;

endmodule

// File: tb/tb_framebuffer_scanout.sv
// Directed bench for framebuffer_scanout on a small 14x7 raster.
// u_dut runs the normal 8-bit-pixel configuration; u_uf uses one 32-bit
// pixel per word and a 2-deep FIFO so that it starves and flags underflow.
module tb_framebuffer_scanout;

  localparam int HT = 14;
  localparam int VT = 7;
  localparam int FR = HT * VT;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic [15:0] base;
  logic [15:0] rd_address;
  logic        rd_en;
  logic [31:0] rd_data = '0;
  logic        de, hsync, vsync, vblank_irq, underflow;
  logic [7:0]  pixel;

  logic        en_u;
  logic [15:0] base_u = 16'h0000;
  logic [15:0] rd_address_u;
  logic        rd_en_u;
  logic [31:0] rd_data_u = '0;
  logic        de_u, hsync_u, vsync_u, vblank_irq_u, underflow_u;
  logic [31:0] pixel_u;

  int tests = 0;
  int fails = 0;
  int n, cur_s, rc;
  logic        exp_en   [0:5];
  logic [15:0] exp_base [0:5];

  always #5 clk = ~clk;

  framebuffer_scanout #(
    .WIDTH(32), .ADDR_WIDTH(16), .PIX_BITS(8),
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .FIFO_DEPTH(4)
  ) u_dut (
    .clk(clk), .reset_sink_reset_n(rst_n), .enable(en), .base_address(base),
    .rd_address(rd_address), .rd_en(rd_en), .rd_data(rd_data),
    .de(de), .hsync(hsync), .vsync(vsync), .pixel(pixel),
    .vblank_irq(vblank_irq), .underflow(underflow)
  );

  framebuffer_scanout #(
    .WIDTH(32), .ADDR_WIDTH(16), .PIX_BITS(32),
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .FIFO_DEPTH(2)
  ) u_uf (
    .clk(clk), .reset_sink_reset_n(rst_n), .enable(en_u), .base_address(base_u),
    .rd_address(rd_address_u), .rd_en(rd_en_u), .rd_data(rd_data_u),
    .de(de_u), .hsync(hsync_u), .vsync(vsync_u), .pixel(pixel_u),
    .vblank_irq(vblank_irq_u), .underflow(underflow_u)
  );

  function automatic logic [31:0] ram_word(input logic [15:0] a);
    logic [15:0] j;
    j = a - 16'h0010;
    return 32'h03020100 + 32'(j) * 32'h04040404;
  endfunction

  // Sync-read RAM models: data valid the clock after the strobe.
  always @(posedge clk) begin
    if (rd_en)   rd_data   <= ram_word(rd_address);
    if (rd_en_u) rd_data_u <= 32'hA5000000 | 32'(rd_address_u);
  end

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s at step %0d: observed %h, expected %h", tag, n, obs, exp);
    end
  endtask

  task automatic chk_reset_outputs();
    check32("rst_de",       32'(de),         32'd0);
    check32("rst_hsync",    32'(hsync),      32'd1);
    check32("rst_vsync",    32'(vsync),      32'd1);
    check32("rst_pixel",    32'(pixel),      32'd0);
    check32("rst_irq",      32'(vblank_irq), 32'd0);
    check32("rst_uf",       32'(underflow),  32'd0);
    check32("rst_rd_en",    32'(rd_en),      32'd0);
    check32("rst_rd_addr",  32'(rd_address), 32'd0);
    check32("rst_u_uf",     32'(underflow_u), 32'd0);
    check32("rst_u_rd_en",  32'(rd_en_u),    32'd0);
  endtask

  // Raster model of output index t = n-1 for the main instance.
  task automatic check_cycle();
    int t, h, v, s, p;
    logic        e_de;
    logic [7:0]  e_pix;
    logic [31:0] w;
    logic [15:0] e_addr;
    t = n - 1;
    h = t % HT;
    v = (t / HT) % VT;
    s = (t + HT) / FR;
    if (s != cur_s) begin
      check32("read_count", 32'(rc), exp_en[cur_s] ? 32'd8 : 32'd0);
      cur_s = s;
      rc = 0;
    end
    e_de = (h < 8) && (v < 4);
    check32("de",    32'(de),         32'(e_de));
    check32("hsync", 32'(hsync),      32'(!(h >= 10 && h < 12)));
    check32("vsync", 32'(vsync),      32'(v != 5));
    check32("irq",   32'(vblank_irq), 32'(h == 0 && v == 4));
    check32("uf",    32'(underflow),  32'd0);
    e_pix = '0;
    if (e_de && exp_en[s]) begin
      p = v * 8 + h;
      w = ram_word(exp_base[s] + 16'(p / 4));
      e_pix = w[(p % 4) * 8 +: 8];
    end
    check32("pixel", 32'(pixel), 32'(e_pix));
    if (!exp_en[s]) begin
      check32("rd_en_off", 32'(rd_en), 32'd0);
    end else if (rd_en) begin
      e_addr = exp_base[s] + 16'(rc);
      check32("rd_addr", 32'(rd_address), 32'(e_addr));
      rc++;
    end
  endtask

  task automatic run_to(input int stop);
    while (n < stop) begin
      @(negedge clk);
      n++;
      check_cycle();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    base  = 16'h0010;
    en_u  = 1'b1;
    n = 0; cur_s = 0; rc = 0;
    exp_en[0] = 1'b0; exp_base[0] = 16'h0000;
    exp_en[1] = 1'b1; exp_base[1] = 16'h0010;
    exp_en[2] = 1'b1; exp_base[2] = 16'hFFFE;
    exp_en[3] = 1'b1; exp_base[3] = 16'hFFFE;
    exp_en[4] = 1'b0; exp_base[4] = 16'hFFFE;
    exp_en[5] = 1'b1; exp_base[5] = 16'h0010;
    repeat (3) @(negedge clk);
    chk_reset_outputs();
    rst_n = 1'b1;

    // Starving instance: two prefetched words, then an empty FIFO on pixel 2.
    run_to(99);
    check32("u_pix0", pixel_u, 32'hA5000000);
    check32("u_uf0",  32'(underflow_u), 32'd0);
    run_to(100);
    check32("u_pix1", pixel_u, 32'hA5000001);
    check32("u_uf1",  32'(underflow_u), 32'd0);
    run_to(101);
    check32("u_pix2", pixel_u, 32'd0);
    check32("u_de2",  32'(de_u), 32'd1);
    check32("u_uf2",  32'(underflow_u), 32'd1);

    run_to(150);
    base = 16'hFFFE;
    en_u = 1'b0;
    run_to(182);
    check32("u_uf_hold", 32'(underflow_u), 32'd1);
    run_to(183);
    check32("u_uf_clr",  32'(underflow_u), 32'd0);
    run_to(200);
    check32("u_de_off_frame", 32'(de_u), 32'd1);
    check32("u_pix_off",  pixel_u, 32'd0);
    check32("u_uf_off",   32'(underflow_u), 32'd0);
    check32("u_rd_off",   32'(rd_en_u), 32'd0);

    run_to(315);
    en = 1'b0;
    run_to(420);
    en   = 1'b1;
    base = 16'h0010;
    run_to(508);

    // Asynchronous reset mid active line.
    check32("pre_rst_de", 32'(de), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    n = 0; cur_s = 0; rc = 0;
    exp_en[2] = 1'b1; exp_base[2] = 16'h0010;
    run_to(200);
    check32("u_uf_after_rst", 32'(underflow_u), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
